// File: rtl/cp0_irq_timer.sv
// CP0 Count/Compare timer, Cause.IP composition and interrupt priority/vector generation.
// Hardware lines are synchronised internally; int_req/int_num are registered.
module cp0_irq_timer #(
    parameter int unsigned N_HW_INT    = 6,
    parameter int unsigned COUNT_DIV   = 2,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMER_LINE  = 7,
    parameter int unsigned VEC_SPACING = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [6:0]          addr,
    input  logic [31:0]         data_i,
    output logic [31:0]         data_o,
    input  logic [N_HW_INT-1:0] hw_int,
    input  logic [7:0]          status_im,
    input  logic                status_ie,
    input  logic                status_exl,
    input  logic                status_erl,
    input  logic                exc_commit,
    input  logic                cause_iv,
    input  logic                vint_en,
    input  logic [31:0]         ebase,
    output logic [7:0]          ip,
    output logic                ti,
    output logic                int_req,
    output logic [2:0]          int_num,
    output logic [31:0]         int_handler
);

    localparam int unsigned DIV_W     = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam int unsigned VEC_SHIFT = $clog2(VEC_SPACING);

    // {reg[4:0], sel[1:0]}
    localparam logic [6:0] ADDR_COUNT   = {5'd9, 2'd0};
    localparam logic [6:0] ADDR_COMPARE = {5'd11, 2'd0};
    localparam logic [6:0] ADDR_CAUSE   = {5'd13, 2'd0};

    logic [DIV_W-1:0]    r_div_cnt;
    logic [31:0]         r_count;
    logic [31:0]         r_compare;
    logic                r_ti;
    logic                r_cnt_upd;
    logic [1:0]          r_sw_ip;
    logic [N_HW_INT-1:0] r_sync [SYNC_STAGES];
    logic                r_int_req;
    logic [2:0]          r_int_num;

    logic                w_tick;
    logic                w_cnt_wr;
    logic                w_cmp_wr;
    logic                w_cau_wr;
    logic [DIV_W-1:0]    w_div_d;
    logic [31:0]         w_count_d;
    logic                w_ti_d;
    logic [7:0]          w_hw_ip;
    logic [7:0]          w_ip;
    logic [7:0]          w_pend;
    logic [2:0]          w_int_num_d;
    logic                w_int_req_d;
    logic [31:0]         w_vec_off;

    assign w_cnt_wr = we && (addr == ADDR_COUNT);
    assign w_cmp_wr = we && (addr == ADDR_COMPARE);
    assign w_cau_wr = we && (addr == ADDR_CAUSE);
    assign w_tick   = (r_div_cnt == DIV_W'(COUNT_DIV - 1));

    always_comb begin
        w_div_d   = r_div_cnt + DIV_W'(1);
        w_count_d = r_count;
        if (w_cnt_wr) begin
            w_div_d   = '0;
            w_count_d = data_i;
        end else if (w_tick) begin
            w_div_d   = '0;
            w_count_d = r_count + 32'd1;
        end
    end

    // r_cnt_upd marks a cycle in which Count has just changed, so equality only fires
    // on Count movement and never on a Compare write alone.
    always_comb begin
        w_ti_d = r_ti;
        if (w_cmp_wr) begin
            w_ti_d = 1'b0;
        end else if (r_cnt_upd && (r_count == r_compare)) begin
            w_ti_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_count   <= '0;
            r_compare <= '0;
            r_ti      <= 1'b0;
            r_cnt_upd <= 1'b0;
            r_sw_ip   <= '0;
        end else begin
            r_div_cnt <= w_div_d;
            r_count   <= w_count_d;
            r_ti      <= w_ti_d;
            r_cnt_upd <= w_cnt_wr | w_tick;
            if (w_cmp_wr) begin
                r_compare <= data_i;
            end
            if (w_cau_wr) begin
                r_sw_ip <= data_i[9:8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
        end else begin
            r_sync[0] <= hw_int;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    always_comb begin
        w_hw_ip = '0;
        for (int i = 0; i < N_HW_INT; i++) begin
            w_hw_ip[2+i] = r_sync[SYNC_STAGES-1][i];
        end
    end

    assign w_ip   = w_hw_ip | (8'(r_ti) << TIMER_LINE) | {6'b0, r_sw_ip};
    assign w_pend = w_ip & status_im;

    always_comb begin
        w_int_num_d = '0;
        for (int i = 0; i < 8; i++) begin
            if (w_pend[i]) begin
                w_int_num_d = 3'(i);
            end
        end
    end

    assign w_int_req_d = (|w_pend) & status_ie & ~status_exl & ~status_erl & ~exc_commit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_int_req <= 1'b0;
            r_int_num <= '0;
        end else begin
            r_int_req <= w_int_req_d;
            r_int_num <= w_int_num_d;
        end
    end

    assign w_vec_off = {29'b0, r_int_num} << VEC_SHIFT;

    always_comb begin
        if (!cause_iv) begin
            int_handler = ebase + 32'h0000_0180;
        end else if (!vint_en) begin
            int_handler = ebase + 32'h0000_0200;
        end else begin
            int_handler = ebase + 32'h0000_0200 + w_vec_off;
        end
    end

    // Cause.TI sits at bit 30.
    always_comb begin
        data_o = '0;
        case (addr)
            ADDR_COUNT:   data_o = r_count;
            ADDR_COMPARE: data_o = r_compare;
            ADDR_CAUSE:   data_o = {1'b0, r_ti, 14'b0, w_ip, 8'b0};
            default:      data_o = '0;
        endcase
    end

    assign ip      = w_ip;
    assign ti      = r_ti;
    assign int_req = r_int_req;
    assign int_num = r_int_num;

endmodule
